// File: rtl/ftf_decoder_42.sv
// Fibonacci transition-free (FTF) TSV codeword decoder: a 3-stage pipeline that turns a
// 42-bit codeword into its Fibonacci-weighted value and keeps saturating violation statistics.
`ifndef FBLEN42
`define FBLEN42 30
`endif

module ftf_decoder_42 #(
   parameter int CNT_W = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [41:0]          tsv_in,
   input  logic                 in_valid,
   input  logic                 cnt_clr,
   output logic [`FBLEN42-1:0]  data_out,
   output logic                 out_valid,
   output logic                 code_err,
   output logic                 viol_sticky,
   output logic [CNT_W-1:0]     viol_count
);

   localparam int DW = `FBLEN42;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Weight of wire n: W[0]=W[1]=1, then each is the sum of the previous two.
   function automatic logic [DW-1:0] fibWeight(input int n);
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] t;
      a = DW'(1);
      b = DW'(1);
      for (int k = 2; k <= n; k++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   logic [41:0]   s1Data;
   logic          s1Valid;
   logic          s1Err;
   logic [DW-1:0] loSum;
   logic [DW-1:0] hiSum;
   logic [DW-1:0] s2Lo;
   logic [DW-1:0] s2Hi;
   logic          s2Valid;
   logic          s2Err;

   // Even pairs may not rise (0->1) and odd pairs may not fall (1->0) going up the bus.
   always_comb begin
      s1Err = 1'b0;
      for (int j = 0; j < 41; j++) begin
         if ((j % 2) == 0) begin
            if (!s1Data[j] && s1Data[j+1]) s1Err = 1'b1;
         end else begin
            if (s1Data[j] && !s1Data[j+1]) s1Err = 1'b1;
         end
      end
   end

   always_comb begin
      loSum = '0;
      hiSum = '0;
      for (int i = 0; i <= 20; i++) begin
         if (s1Data[i]) loSum = loSum + fibWeight(i);
      end
      for (int i = 21; i <= 41; i++) begin
         if (s1Data[i]) hiSum = hiSum + fibWeight(i);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1Data      <= '0;
         s1Valid     <= 1'b0;
         s2Lo        <= '0;
         s2Hi        <= '0;
         s2Valid     <= 1'b0;
         s2Err       <= 1'b0;
         data_out    <= '0;
         out_valid   <= 1'b0;
         code_err    <= 1'b0;
         viol_sticky <= 1'b0;
         viol_count  <= '0;
      end else begin
         s1Data    <= tsv_in;
         s1Valid   <= in_valid;
         s2Lo      <= loSum;
         s2Hi      <= hiSum;
         s2Valid   <= s1Valid;
         s2Err     <= s1Err;
         out_valid <= s2Valid;
         if (s2Valid) begin
            data_out <= s2Lo + s2Hi;
            code_err <= s2Err;
         end
         // Clear beats a violation exiting on the same edge.
         if (cnt_clr) begin
            viol_count  <= '0;
            viol_sticky <= 1'b0;
         end else if (s2Valid && s2Err) begin
            viol_sticky <= 1'b1;
            if (viol_count != CNT_MAX) viol_count <= viol_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ftf_decoder_42.sv
// Randomized bench for ftf_decoder_42: a queue-based latency model plus arithmetic
// Fibonacci decode and pair-rule checks predict every output cycle.
`ifndef FBLEN42
`define FBLEN42 30
`endif

module tb_ftf_decoder_42;

   localparam int DW = `FBLEN42;

   typedef struct {
      bit            valid;
      logic [DW-1:0] data;
      bit            err;
   } entry_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [41:0]   tsv_in = '0;
   logic          in_valid = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [DW-1:0] data_out;
   logic          out_valid;
   logic          code_err;
   logic          viol_sticky;
   logic [15:0]   viol_count;
   logic [DW-1:0] smallData;
   logic          smallValid;
   logic          smallErr;
   logic          smallSticky;
   logic [3:0]    smallCount;

   int vectors = 0;
   int miscompares = 0;

   entry_t        pipeQ[$];
   bit            expValid;
   logic [DW-1:0] expData;
   bit            expErr;
   bit            expSticky;
   int            expCount;

   ftf_decoder_42 dut (
      .clock(clock), .reset_n(reset_n), .tsv_in(tsv_in), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .data_out(data_out), .out_valid(out_valid),
      .code_err(code_err), .viol_sticky(viol_sticky), .viol_count(viol_count)
   );

   ftf_decoder_42 #(.CNT_W(4)) dutSmall (
      .clock(clock), .reset_n(reset_n), .tsv_in(tsv_in), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .data_out(smallData), .out_valid(smallValid),
      .code_err(smallErr), .viol_sticky(smallSticky), .viol_count(smallCount)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] refDecode(input logic [41:0] w);
      longint wt[42];
      longint s;
      wt[0] = 1;
      wt[1] = 1;
      for (int i = 2; i < 42; i++) wt[i] = wt[i-1] + wt[i-2];
      s = 0;
      for (int i = 0; i < 42; i++) if (w[i]) s += wt[i];
      return s[DW-1:0];
   endfunction

   function automatic bit refErr(input logic [41:0] w);
      bit e;
      e = 1'b0;
      for (int j = 0; j < 41; j++) begin
         if ((j % 2) == 0 && w[j] == 1'b0 && w[j+1] == 1'b1) e = 1'b1;
         if ((j % 2) == 1 && w[j] == 1'b1 && w[j+1] == 1'b0) e = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [41:0] randWord();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[41:0];
   endfunction

   // Codeword that obeys the transition rule everywhere.
   function automatic logic [41:0] legalWord();
      logic [41:0] w;
      w[0] = 1'($urandom_range(0, 1));
      for (int j = 0; j < 41; j++) begin
         if ((j % 2) == 0) w[j+1] = w[j] ? 1'($urandom_range(0, 1)) : 1'b0;
         else              w[j+1] = w[j] ? 1'b1 : 1'($urandom_range(0, 1));
      end
      return w;
   endfunction

   function automatic logic [15:0] sat16(input int c);
      return (c > 65535) ? 16'hFFFF : c[15:0];
   endfunction

   function automatic logic [3:0] sat4(input int c);
      return (c > 15) ? 4'hF : c[3:0];
   endfunction

   function automatic void modelReset();
      entry_t idle;
      idle.valid = 1'b0;
      idle.data  = '0;
      idle.err   = 1'b0;
      pipeQ.delete();
      pipeQ.push_back(idle);
      pipeQ.push_back(idle);
      expValid  = 1'b0;
      expData   = '0;
      expErr    = 1'b0;
      expSticky = 1'b0;
      expCount  = 0;
   endfunction

   // One clock: drive on the falling edge, advance the model after the rising edge.
   task automatic applyStimulus(input logic rst, input logic v, input logic [41:0] d,
                                input logic clr);
      entry_t e;
      entry_t o;
      @(negedge clock);
      reset_n  = rst;
      in_valid = v;
      tsv_in   = d;
      cnt_clr  = clr;
      @(posedge clock);
      #1;
      if (!rst) begin
         modelReset();
      end else begin
         e.valid = v;
         e.data  = refDecode(d);
         e.err   = refErr(d);
         pipeQ.push_back(e);
         o = pipeQ.pop_front();
         expValid = o.valid;
         if (o.valid) begin
            expData = o.data;
            expErr  = o.err;
         end
         if (clr) begin
            expCount  = 0;
            expSticky = 1'b0;
         end else if (o.valid && o.err) begin
            expCount++;
            expSticky = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 42'h2, 1'b0);
      vectors++;
      if ({out_valid, code_err, data_out, viol_sticky, viol_count} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_state got v=%0b e=%0b d=%0d s=%0b c=%0d want all zero",
                  out_valid, code_err, data_out, viol_sticky, viol_count);
      end
   endtask

   task automatic test_known_vectors();
      logic [41:0] words[5] = '{42'h0, 42'h1, 42'h7, 42'h2, 42'h3FF_FFFF_FFFF};
      logic [DW-1:0] wantD[5] = '{30'd0, 30'd1, 30'd4, 30'd1, 30'd701408732};
      bit wantE[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 1'b1, words[k], 1'b0);
         applyStimulus(1'b1, 1'b0, '0, 1'b0);
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL early_valid word %0d got out_valid=%0b want 0", k, out_valid);
         end
         applyStimulus(1'b1, 1'b0, '0, 1'b0);
         vectors++;
         if ({out_valid, data_out, code_err} !== {1'b1, wantD[k], wantE[k]}) begin
            miscompares++;
            $display("[TB] FAIL known_word %0d got v=%0b d=%0d e=%0b want v=1 d=%0d e=%0b",
                     k, out_valid, data_out, code_err, wantD[k], wantE[k]);
         end
         if (k >= 3) begin
            vectors++;
            if ({viol_count, viol_sticky} !== {16'd1, 1'b1}) begin
               miscompares++;
               $display("[TB] FAIL known_count %0d got c=%0d s=%0b want c=1 s=1",
                        k, viol_count, viol_sticky);
            end
         end
      end
   endtask

   task automatic test_random(input int n, input bit legalOnly);
      logic [41:0] w;
      for (int k = 0; k < n; k++) begin
         w = legalOnly ? legalWord() : randWord();
         applyStimulus(1'b1, legalOnly ? 1'b1 : 1'($urandom_range(0, 4) != 0), w,
                       legalOnly ? 1'b0 : 1'($urandom_range(0, 19) == 0));
         vectors++;
         if ({out_valid, code_err, data_out, viol_sticky, viol_count, smallCount} !==
             {expValid, expErr, expData, expSticky, sat16(expCount), sat4(expCount)}) begin
            miscompares++;
            $display("[TB] FAIL random cyc %0d got v=%0b e=%0b d=%0d s=%0b c=%0d c4=%0d want v=%0b e=%0b d=%0d s=%0b c=%0d c4=%0d",
                     k, out_valid, code_err, data_out, viol_sticky, viol_count, smallCount,
                     expValid, expErr, expData, expSticky, sat16(expCount), sat4(expCount));
         end
      end
   endtask

   task automatic test_bubble();
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, (k != 4), legalWord(), 1'b0);
         if (k >= 2) begin
            vectors++;
            if ({out_valid, code_err, data_out} !== {(k != 6), 1'b0, expData}) begin
               miscompares++;
               $display("[TB] FAIL bubble cyc %0d got v=%0b e=%0b d=%0d want v=%0b e=0 d=%0d",
                        k, out_valid, code_err, data_out, (k != 6), expData);
            end
         end
      end
   endtask

   task automatic test_midstream_reset();
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 42'h2, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({out_valid, code_err, data_out, viol_sticky, viol_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset cyc %0d got v=%0b e=%0b d=%0d s=%0b c=%0d want all zero",
                     k, out_valid, code_err, data_out, viol_sticky, viol_count);
         end
         applyStimulus(1'b1, 1'b0, '0, 1'b0);
      end
   endtask

   task automatic test_clear_collision();
      applyStimulus(1'b1, 1'b1, 42'h2, 1'b0);
      applyStimulus(1'b1, 1'b1, 42'h2, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      vectors++;
      if ({viol_count, viol_sticky} !== {16'd1, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL pre_clear got c=%0d s=%0b want c=1 s=1", viol_count, viol_sticky);
      end
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      vectors++;
      if ({out_valid, code_err, data_out, viol_count, viol_sticky} !== {1'b1, 1'b1, 30'd1, 16'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL clear_wins got v=%0b e=%0b d=%0d c=%0d s=%0b want v=1 e=1 d=1 c=0 s=0",
                  out_valid, code_err, data_out, viol_count, viol_sticky);
      end
   endtask

   task automatic test_saturation();
      logic [41:0] w;
      for (int k = 0; k < 20; k++) begin
         w = randWord();
         w[1:0] = 2'b10;
         applyStimulus(1'b1, 1'b1, w, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      vectors++;
      if ({smallCount, smallSticky, viol_count} !== {4'd15, 1'b1, 16'd20}) begin
         miscompares++;
         $display("[TB] FAIL saturation got c4=%0d s4=%0b c16=%0d want c4=15 s4=1 c16=20",
                  smallCount, smallSticky, viol_count);
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_known_vectors();
      test_reset();
      test_random(600, 1'b0);
      test_random(2000, 1'b1);
      test_bubble();
      test_midstream_reset();
      test_reset();
      test_clear_collision();
      test_reset();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
